// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants, FSM state type and helpers for the register-file dump reader.
// Optional feature macro: DUMP_PARITY_EN (widens the capture word by one parity bit).
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    localparam logic [4:0]        XZR_ADDR  = 5'd31;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

`ifdef DUMP_PARITY_EN
    localparam int CAP_W = DATA_W + ADDR_W + 2;
`else
    localparam int CAP_W = DATA_W + ADDR_W + 1;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } dump_state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Control, register-file read port and output stream of the dump reader.
// DUMP_PARITY_EN adds out_parity to the stream.
interface regfile_dump_reader_if;
    import regfile_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
`ifdef DUMP_PARITY_EN
    logic              out_parity;
`endif

    modport master (
        input  start,
        output busy,
        output done,
        output rf_rd_addr,
        input  rf_rd_data,
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_data,
`ifdef DUMP_PARITY_EN
        output out_parity,
`endif
        output out_last
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  rf_rd_addr,
        output rf_rd_data,
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_data,
`ifdef DUMP_PARITY_EN
        input  out_parity,
`endif
        input  out_last
    );

endinterface

// File: rtl/regfile_dump_reader_capture.sv
// Beat capture register: loads {parity?, last, addr, data} when enabled, clears on reset.
// Width grows by one bit when DUMP_PARITY_EN is defined (set via WIDTH from the top).
module dump_capture_reg
    import regfile_pkg::*;
#(
    parameter int WIDTH = CAP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_reg[gi] <= 1'b0;
                end else if (load) begin
                    q_reg[gi] <= d[gi];
                end
            end
        end
    endgenerate

    assign q = q_reg;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks X0..X31 through one register-file read port and streams (addr, data) beats.
// DUMP_PARITY_EN adds an even-parity bit captured alongside each beat.
module regfile_dump_reader
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    regfile_dump_reader_if.master dump
);

    dump_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              load_en;
    logic              is_xzr;
    logic              is_last;
    logic [DATA_W-1:0] cap_data;
    logic [CAP_W-1:0]  cap_d;
    logic [CAP_W-1:0]  cap_q;
    logic              cap_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // out_valid is exactly the HOLD state, so a handshake in HOLD is just out_ready.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        load_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dump.start) begin
                    ptr_next   = '0;
                    state_next = READ;
                end
            end
            READ: begin
                load_en    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (dump.out_ready) begin
                    if (cap_last) begin
                        state_next = DONE;
                    end else begin
                        ptr_next   = ptr_reg + ADDR_W'(1);
                        state_next = READ;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // X31 reads as the zero register regardless of what the file holds.
    assign is_xzr   = (ptr_reg == XZR_ADDR);
    assign is_last  = (ptr_reg == LAST_ADDR);
    assign cap_data = is_xzr ? '0 : dump.rf_rd_data;

`ifdef DUMP_PARITY_EN
    assign cap_d = {even_parity(cap_data), is_last, ptr_reg, cap_data};
`else
    assign cap_d = {is_last, ptr_reg, cap_data};
`endif

    dump_capture_reg #(
        .WIDTH(CAP_W)
    ) u_capture (
        .clk  (clk),
        .reset(reset),
        .load (load_en),
        .d    (cap_d),
        .q    (cap_q)
    );

    assign cap_last      = cap_q[DATA_W+ADDR_W];
    assign dump.out_data = cap_q[DATA_W-1:0];
    assign dump.out_addr = cap_q[DATA_W +: ADDR_W];
    assign dump.out_last = cap_last;
`ifdef DUMP_PARITY_EN
    assign dump.out_parity = cap_q[DATA_W+ADDR_W+1];
`endif

    assign dump.out_valid  = (state_reg == HOLD);
    assign dump.busy       = (state_reg == READ) || (state_reg == HOLD);
    assign dump.done       = (state_reg == DONE);
    assign dump.rf_rd_addr = (state_reg == IDLE) ? '0 : ptr_reg;

endmodule
